// File: rtl/bitstream_window_ctrl.sv
// Bitstream window controller: 64-bit left-aligned bit buffer refilled with 32-bit words,
// presenting a 32-bit window to the CAVLC decode FSM and applying its shift requests.
module bitstream_window_ctrl #(
    parameter int WORD_W = 32,
    parameter int BUF_W  = 64,
    parameter int POS_W  = 24
) (
    input  logic              Clk,
    input  logic              Reset,
    input  logic              Start,
    input  logic [WORD_W-1:0] WordData,
    input  logic              WordValid,
    output logic              WordReady,
    input  logic              ShiftEn,
    input  logic [4:0]        NumShift,
    output logic [WORD_W-1:0] Window,
    output logic              BarrelShifterReady,
    output logic [6:0]        BitCount,
    output logic [POS_W-1:0]  BitPos,
    output logic              ByteAligned,
    output logic              ShiftError
);

    logic [BUF_W-1:0] bitBuf;
    logic [6:0]       bitCount;
    logic [POS_W-1:0] bitPos;
    logic             shiftErr;

    logic             loadAcc;
    logic             shiftAcc;
    logic             shiftBad;
    logic [4:0]       shAmt;
    logic [6:0]       remCount;
    logic [6:0]       nextCount;
    logic [BUF_W-1:0] shiftedBuf;
    logic [BUF_W-1:0] loadBits;
    logic [BUF_W-1:0] nextBuf;

    assign Window             = bitBuf[BUF_W-1 -: WORD_W];
    assign BarrelShifterReady = (bitCount >= 7'd32);
    assign BitCount           = bitCount;
    assign BitPos             = bitPos;
    assign ByteAligned        = (bitPos[2:0] == 3'b000);
    assign ShiftError         = shiftErr;
    assign WordReady          = !Reset && !Start && (bitCount <= 7'd32);

    // Shift is applied first; the new word then lands right after the surviving bits.
    always_comb begin
        loadAcc    = WordValid && WordReady;
        shiftAcc   = ShiftEn && BarrelShifterReady;
        shiftBad   = ShiftEn && !BarrelShifterReady;
        shAmt      = shiftAcc ? NumShift : 5'd0;
        remCount   = bitCount - {2'b00, shAmt};
        shiftedBuf = bitBuf << shAmt;
        loadBits   = '0;
        if (loadAcc) begin
            loadBits = {WordData, {(BUF_W-WORD_W){1'b0}}} >> remCount;
        end
        nextBuf   = shiftedBuf | loadBits;
        nextCount = remCount + (loadAcc ? 7'd32 : 7'd0);
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            bitBuf   <= '0;
            bitCount <= '0;
            bitPos   <= '0;
            shiftErr <= 1'b0;
        end else if (Start) begin
            bitBuf   <= '0;
            bitCount <= '0;
            bitPos   <= '0;
            shiftErr <= 1'b0;
        end else begin
            bitBuf   <= nextBuf;
            bitCount <= nextCount;
            bitPos   <= bitPos + {{(POS_W-5){1'b0}}, shAmt};
            if (shiftBad) begin
                shiftErr <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_bitstream_window_ctrl.sv
// Directed self-checking bench for bitstream_window_ctrl with hand-computed expectations.
module tb_bitstream_window_ctrl;

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        Start = 1'b0;
    logic [31:0] WordData = '0;
    logic        WordValid = 1'b0;
    logic        WordReady;
    logic        ShiftEn = 1'b0;
    logic [4:0]  NumShift = '0;
    logic [31:0] Window;
    logic        BarrelShifterReady;
    logic [6:0]  BitCount;
    logic [23:0] BitPos;
    logic        ByteAligned;
    logic        ShiftError;

    int vectors = 0;
    int miscompares = 0;

    bitstream_window_ctrl dut (
        .Clk(Clk), .Reset(Reset), .Start(Start),
        .WordData(WordData), .WordValid(WordValid), .WordReady(WordReady),
        .ShiftEn(ShiftEn), .NumShift(NumShift), .Window(Window),
        .BarrelShifterReady(BarrelShifterReady), .BitCount(BitCount),
        .BitPos(BitPos), .ByteAligned(ByteAligned), .ShiftError(ShiftError)
    );

    always #5 Clk = ~Clk;

    task automatic tick;
        @(posedge Clk);
        #1;
    endtask

    task automatic idleInputs;
        Start = 1'b0; WordValid = 1'b0; ShiftEn = 1'b0; NumShift = '0;
    endtask

    task automatic doStart;
        idleInputs(); Start = 1'b1; tick(); Start = 1'b0;
    endtask

    task automatic loadWord(input logic [31:0] d);
        WordData = d; WordValid = 1'b1; tick(); WordValid = 1'b0;
    endtask

    task automatic shiftBits(input logic [4:0] n);
        ShiftEn = 1'b1; NumShift = n; tick(); ShiftEn = 1'b0; NumShift = '0;
    endtask

    task automatic test_reset;
        #2;
        vectors++; if (WordReady !== 1'b0) begin miscompares++; $display("FAIL rst_wready got %0b want 0", WordReady); end
        vectors++; if (Window !== 32'h0) begin miscompares++; $display("FAIL rst_window got %h want 0", Window); end
        vectors++; if (BitCount !== 7'd0) begin miscompares++; $display("FAIL rst_count got %0d want 0", BitCount); end
        vectors++; if (BarrelShifterReady !== 1'b0) begin miscompares++; $display("FAIL rst_ready got %0b want 0", BarrelShifterReady); end
        vectors++; if (ByteAligned !== 1'b1) begin miscompares++; $display("FAIL rst_aligned got %0b want 1", ByteAligned); end
        vectors++; if (ShiftError !== 1'b0) begin miscompares++; $display("FAIL rst_err got %0b want 0", ShiftError); end
        tick(); tick();
        Reset = 1'b0;
        #1;
        vectors++; if (WordReady !== 1'b1) begin miscompares++; $display("FAIL rel_wready got %0b want 1", WordReady); end
    endtask

    task automatic test_single_load;
        loadWord(32'hDEADBEEF);
        vectors++; if (BitCount !== 7'd32) begin miscompares++; $display("FAIL load1_count got %0d want 32", BitCount); end
        vectors++; if (Window !== 32'hDEADBEEF) begin miscompares++; $display("FAIL load1_window got %h want deadbeef", Window); end
        vectors++; if (BarrelShifterReady !== 1'b1) begin miscompares++; $display("FAIL load1_ready got %0b want 1", BarrelShifterReady); end
        vectors++; if (WordReady !== 1'b1) begin miscompares++; $display("FAIL load1_wready got %0b want 1", WordReady); end
    endtask

    task automatic test_two_loads_shift;
        doStart();
        loadWord(32'hDEADBEEF);
        loadWord(32'h12345678);
        vectors++; if (BitCount !== 7'd64) begin miscompares++; $display("FAIL full_count got %0d want 64", BitCount); end
        vectors++; if (WordReady !== 1'b0) begin miscompares++; $display("FAIL full_wready got %0b want 0", WordReady); end
        shiftBits(5'd4);
        vectors++; if (Window !== 32'hEADBEEF1) begin miscompares++; $display("FAIL sh4_window got %h want eadbeef1", Window); end
        vectors++; if (BitCount !== 7'd60) begin miscompares++; $display("FAIL sh4_count got %0d want 60", BitCount); end
        vectors++; if (WordReady !== 1'b0) begin miscompares++; $display("FAIL sh4_wready got %0b want 0", WordReady); end
        vectors++; if (BitPos !== 24'd4 || ByteAligned !== 1'b0) begin miscompares++; $display("FAIL sh4_pos got %0d/%0b want 4/0", BitPos, ByteAligned); end
        shiftBits(5'd28);
        vectors++; if (Window !== 32'h12345678) begin miscompares++; $display("FAIL sh28_window got %h want 12345678", Window); end
        vectors++; if (BitCount !== 7'd32) begin miscompares++; $display("FAIL sh28_count got %0d want 32", BitCount); end
        vectors++; if (BitPos !== 24'd32 || ByteAligned !== 1'b1) begin miscompares++; $display("FAIL sh28_pos got %0d/%0b want 32/1", BitPos, ByteAligned); end
        vectors++; if (WordReady !== 1'b1) begin miscompares++; $display("FAIL sh28_wready got %0b want 1", WordReady); end
    endtask

    task automatic test_back_to_back;
        doStart();
        loadWord(32'hDEADBEEF);
        WordData = 32'h12345678; WordValid = 1'b1; ShiftEn = 1'b1; NumShift = 5'd8;
        tick();
        idleInputs();
        vectors++; if (BitCount !== 7'd56) begin miscompares++; $display("FAIL combo_count got %0d want 56", BitCount); end
        vectors++; if (Window !== 32'hADBEEF12) begin miscompares++; $display("FAIL combo_window got %h want adbeef12", Window); end
        vectors++; if (BitPos !== 24'd8 || ByteAligned !== 1'b1) begin miscompares++; $display("FAIL combo_pos got %0d/%0b want 8/1", BitPos, ByteAligned); end
        ShiftEn = 1'b1; NumShift = 5'd3;
        tick();
        vectors++; if (Window !== 32'h6DF77891) begin miscompares++; $display("FAIL b2b3_window got %h want 6df77891", Window); end
        vectors++; if (BitCount !== 7'd53 || BitPos !== 24'd11 || ByteAligned !== 1'b0) begin miscompares++; $display("FAIL b2b3_state got %0d/%0d/%0b want 53/11/0", BitCount, BitPos, ByteAligned); end
        NumShift = 5'd5;
        tick();
        idleInputs();
        vectors++; if (Window !== 32'hBEEF1234) begin miscompares++; $display("FAIL b2b5_window got %h want beef1234", Window); end
        vectors++; if (BitCount !== 7'd48 || BitPos !== 24'd16 || ByteAligned !== 1'b1) begin miscompares++; $display("FAIL b2b5_state got %0d/%0d/%0b want 48/16/1", BitCount, BitPos, ByteAligned); end
    endtask

    task automatic test_shift_error;
        doStart();
        shiftBits(5'd5);
        vectors++; if (ShiftError !== 1'b1) begin miscompares++; $display("FAIL err_set got %0b want 1", ShiftError); end
        vectors++; if (BitCount !== 7'd0 || BitPos !== 24'd0) begin miscompares++; $display("FAIL err_state got %0d/%0d want 0/0", BitCount, BitPos); end
        WordData = 32'hA5A5A5A5; WordValid = 1'b1; ShiftEn = 1'b1; NumShift = 5'd7;
        tick();
        idleInputs();
        vectors++; if (BitCount !== 7'd32 || Window !== 32'hA5A5A5A5 || BitPos !== 24'd0) begin miscompares++; $display("FAIL err_load got %0d/%h/%0d want 32/a5a5a5a5/0", BitCount, Window, BitPos); end
        shiftBits(5'd0);
        vectors++; if (BitCount !== 7'd32 || Window !== 32'hA5A5A5A5 || BitPos !== 24'd0) begin miscompares++; $display("FAIL sh0 got %0d/%h/%0d want 32/a5a5a5a5/0", BitCount, Window, BitPos); end
        vectors++; if (ShiftError !== 1'b1) begin miscompares++; $display("FAIL err_sticky got %0b want 1", ShiftError); end
        doStart();
        vectors++; if (ShiftError !== 1'b0) begin miscompares++; $display("FAIL err_clear got %0b want 0", ShiftError); end
    endtask

    task automatic test_start_priority;
        doStart();
        loadWord(32'hDEADBEEF);
        WordData = 32'h12345678; WordValid = 1'b1; ShiftEn = 1'b1; NumShift = 5'd24;
        tick();
        idleInputs();
        vectors++; if (BitCount !== 7'd40) begin miscompares++; $display("FAIL pre_start_count got %0d want 40", BitCount); end
        Start = 1'b1; WordData = 32'hCAFEF00D; WordValid = 1'b1; ShiftEn = 1'b1; NumShift = 5'd3;
        #1;
        vectors++; if (WordReady !== 1'b0) begin miscompares++; $display("FAIL start_wready got %0b want 0", WordReady); end
        tick();
        Start = 1'b0; ShiftEn = 1'b0; NumShift = '0;
        vectors++; if (BitCount !== 7'd0 || BitPos !== 24'd0 || Window !== 32'h0) begin miscompares++; $display("FAIL start_clear got %0d/%0d/%h want 0/0/0", BitCount, BitPos, Window); end
        tick();
        WordValid = 1'b0;
        vectors++; if (BitCount !== 7'd32 || Window !== 32'hCAFEF00D) begin miscompares++; $display("FAIL post_start got %0d/%h want 32/cafef00d", BitCount, Window); end
    endtask

    task automatic test_async_reset;
        doStart();
        loadWord(32'hDEADBEEF);
        WordData = 32'h12345678; WordValid = 1'b1; ShiftEn = 1'b1; NumShift = 5'd16;
        tick();
        idleInputs();
        vectors++; if (BitCount !== 7'd48) begin miscompares++; $display("FAIL pre_rst_count got %0d want 48", BitCount); end
        #2;
        Reset = 1'b1;
        #1;
        vectors++; if (BitCount !== 7'd0 || Window !== 32'h0 || BitPos !== 24'd0) begin miscompares++; $display("FAIL arst_state got %0d/%h/%0d want 0/0/0", BitCount, Window, BitPos); end
        vectors++; if (BarrelShifterReady !== 1'b0 || WordReady !== 1'b0 || ByteAligned !== 1'b1 || ShiftError !== 1'b0) begin miscompares++; $display("FAIL arst_flags got %0b%0b%0b%0b want 0010", BarrelShifterReady, WordReady, ByteAligned, ShiftError); end
        tick();
        Reset = 1'b0;
        loadWord(32'hCAFEF00D);
        vectors++; if (Window !== 32'hCAFEF00D || BitCount !== 7'd32) begin miscompares++; $display("FAIL arst_reload got %h/%0d want cafef00d/32", Window, BitCount); end
    endtask

    initial begin
        test_reset();
        test_single_load();
        test_two_loads_shift();
        test_back_to_back();
        test_shift_error();
        test_start_priority();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
